// File: rtl/phy_rx_serial_to_parallel.sv
// phy_rx_serial_to_parallel: per-lane deserializer that aligns on the idle symbol and emits parallel bytes
module phy_rx_serial_to_parallel #(
   parameter int             WIDTH      = 8,
   parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
   parameter int             SYNC_COUNT = 4
) (
   input  logic             clk_8f,
   input  logic             reset_L,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             byte_strobe,
   output logic             active
);
   localparam int CW = $clog2(WIDTH);
   localparam int BW = $clog2(SYNC_COUNT + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [BW-1:0] SC   = BW'(SYNC_COUNT);
   typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;
   state_t            state_q;
   logic [WIDTH-2:0]  sr_q;
   logic [CW-1:0]     bit_cnt_q;
   logic [BW-1:0]     bc_cnt_q;
   logic [WIDTH-1:0]  data_q;
   logic              valid_q;
   logic              strobe_q;
   logic              active_q;
   logic [WIDTH-1:0]  window;
   logic              is_idle;
   logic              boundary;
   assign window      = {sr_q, serial_in};
   assign is_idle     = window == IDLE_SYM;
   assign boundary    = bit_cnt_q == LAST;
   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = active_q;
   // Alignment FSM: hunt for the idle symbol, confirm it at byte spacing, then deliver bytes.
   always_ff @(posedge clk_8f or negedge reset_L) begin
      if (!reset_L) begin
         state_q   <= SEARCH;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         bc_cnt_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         strobe_q  <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         sr_q     <= window[WIDTH-2:0];
         strobe_q <= 1'b0;
         case (state_q)
            SEARCH: begin
               if (is_idle) begin
                  bit_cnt_q <= '0;
                  bc_cnt_q  <= BW'(1);
                  state_q   <= SYNC;
               end
            end
            SYNC: begin
               bit_cnt_q <= boundary ? '0 : bit_cnt_q + 1'b1;
               if (boundary && is_idle) begin
                  bc_cnt_q <= bc_cnt_q + 1'b1;
                  if (bc_cnt_q + 1'b1 == SC) begin
                     state_q  <= ACTIVE;
                     active_q <= 1'b1;
                  end
               end else if (boundary) begin
                  bc_cnt_q <= '0;
                  state_q  <= SEARCH;
               end
            end
            ACTIVE: begin
               bit_cnt_q <= boundary ? '0 : bit_cnt_q + 1'b1;
               if (boundary) begin
                  strobe_q <= 1'b1;
                  valid_q  <= !is_idle;
                  if (!is_idle) data_q <= window;
               end
            end
            default: state_q <= SEARCH;
         endcase
      end
   end
endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// tb_phy_rx_serial_to_parallel: scoreboard bench with a stream-level reference model of lane alignment
module tb_phy_rx_serial_to_parallel;
   localparam logic [7:0] IDLE = 8'hBC;
   localparam int SC = 4;
   typedef struct {
      int         cyc;
      logic [7:0] d;
      logic       v;
   } ev_t;
   logic       clk_8f = 1'b0;
   logic       reset_L = 1'b0;
   logic       serial_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;
   ev_t        exp_q[$];
   bit         stim[$];
   int         act_cyc = -1;
   int         cyc = 0;
   bit         mon_run = 1'b0;
   int         checks = 0;
   int         passed = 0;
   logic [7:0] exp_d = 8'h00;
   logic       exp_v = 1'b0;
   bit         es;

   phy_rx_serial_to_parallel dut (
      .clk_8f(clk_8f), .reset_L(reset_L), .serial_in(serial_in),
      .data_out(data_out), .valid_out(valid_out), .byte_strobe(byte_strobe), .active(active)
   );

   always #5 clk_8f = ~clk_8f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
   endtask

   function automatic void add_byte(input logic [7:0] b);
      for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
   endfunction

   // newest 8 received bits ending at bit i; bits before the stream start are zero
   function automatic logic [7:0] win(input int i);
      logic [7:0] w = 8'h00;
      for (int k = 0; k < 8; k++) w = {w[6:0], (i - 7 + k >= 0) ? stim[i - 7 + k] : 1'b0};
      return w;
   endfunction

   // Stream-level model: locate the first idle that is followed by SC-1 more idles at byte
   // spacing (restarting the hunt one bit after a failed confirmation), then every later
   // byte-spaced symbol is a strobe carrying either data or idle.
   function automatic void model();
      int n = stim.size();
      int i = 0;
      int k;
      act_cyc = -1;
      while (i < n && act_cyc < 0) begin
         if (win(i) == IDLE) begin
            k = 1;
            while (k < SC && i + 8 * k < n && win(i + 8 * k) == IDLE) k++;
            if (k == SC) act_cyc = i + 8 * (SC - 1);
            else if (i + 8 * k >= n) i = n;
            else i = i + 8 * k + 1;
         end else i++;
      end
      if (act_cyc >= 0)
         for (int j = act_cyc + 8; j < n; j += 8) begin
            ev_t e;
            e.cyc = j;
            e.d = win(j);
            e.v = win(j) != IDLE;
            exp_q.push_back(e);
         end
   endfunction

   // Monitor: once per bit, after the sampling edge, compare every output to the scoreboard.
   always @(negedge clk_8f) begin
      if (mon_run) begin
         es = exp_q.size() > 0 && exp_q[0].cyc == cyc;
         if (es) begin
            exp_v = exp_q[0].v;
            if (exp_q[0].v) exp_d = exp_q[0].d;
            void'(exp_q.pop_front());
         end
         check("byte_strobe", 32'(byte_strobe), 32'(es));
         check("data_out", 32'(data_out), 32'(exp_d));
         check("valid_out", 32'(valid_out), 32'(exp_v));
         check("active", 32'(active), 32'(act_cyc >= 0 && cyc >= act_cyc));
         cyc++;
      end
   end

   task automatic run_seg(input bit rst_mid);
      exp_q.delete();
      model();
      reset_L = 1'b0;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk_8f);
         serial_in = ~serial_in;
         #1;
         check("reset_outputs", {data_out, valid_out, byte_strobe, active}, 32'h0);
      end
      @(posedge clk_8f);
      #1;
      reset_L = 1'b1;
      cyc = 0;
      exp_d = 8'h00;
      exp_v = 1'b0;
      for (int i = 0; i < stim.size(); i++) begin
         serial_in = stim[i];
         @(posedge clk_8f);
         #1;
         mon_run = 1'b1;
      end
      @(negedge clk_8f);
      #1;
      mon_run = 1'b0;
      check("events_left", 32'(exp_q.size()), 32'h0);
      if (rst_mid) begin
         reset_L = 1'b0;
         #1;
         check("midreset_clear", {data_out, valid_out, byte_strobe, active}, 32'h0);
      end
      stim.delete();
   endtask

   initial begin
      // aligned lock
      repeat (4) add_byte(IDLE);
      add_byte(8'h01); add_byte(8'h02);
      run_seg(1'b0);
      // misaligned lock after 3 junk bits
      stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
      repeat (4) add_byte(IDLE);
      add_byte(8'hF0);
      run_seg(1'b0);
      // sync break then relock
      add_byte(IDLE); add_byte(IDLE); add_byte(8'h55);
      repeat (4) add_byte(IDLE);
      add_byte(8'h11);
      run_seg(1'b0);
      // idle inside ACTIVE
      repeat (4) add_byte(IDLE);
      add_byte(8'h33); add_byte(IDLE); add_byte(8'h44);
      run_seg(1'b0);
      // reset three bits into a byte while ACTIVE, then realign
      repeat (4) add_byte(IDLE);
      add_byte(8'h33);
      stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
      run_seg(1'b1);
      repeat (4) add_byte(IDLE);
      add_byte(8'h7E);
      run_seg(1'b0);
      // randomized streams
      for (int s = 0; s < 20; s++) begin
         int junk = $urandom_range(0, 12);
         for (int j = 0; j < junk; j++) stim.push_back(1'($urandom));
         repeat ($urandom_range(1, 6)) add_byte(IDLE);
         if ($urandom_range(0, 3) == 0) begin
            add_byte(8'($urandom));
            repeat ($urandom_range(3, 5)) add_byte(IDLE);
         end
         repeat ($urandom_range(4, 12)) add_byte(($urandom_range(0, 4) == 0) ? IDLE : 8'($urandom));
         run_seg(1'($urandom));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
